// File: rtl/i2c_pkg.sv
// Shared command codes, engine states and SCL-level decode helpers for the I2C SCL engine.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START  = 2'b00,
    CMD_XFER   = 2'b01,
    CMD_STOP   = 2'b10,
    CMD_RSTART = 2'b11
  } cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S_WAIT,
    ST_S_HOLD,
    ST_PARK,
    ST_X_LOW,
    ST_X_HIGH,
    ST_P_LOW,
    ST_P_HIGH,
    ST_R_LOW,
    ST_R_HIGH
  } state_t;

  // States in which the engine pulls SCL low.
  function automatic logic scl_held_low(input state_t s);
    return (s == ST_S_HOLD) || (s == ST_PARK) || (s == ST_X_LOW) ||
           (s == ST_P_LOW)  || (s == ST_R_LOW);
  endfunction

  // Released-SCL phases, where a slave may stretch the clock.
  function automatic logic scl_released(input state_t s);
    return (s == ST_S_WAIT) || (s == ST_X_HIGH) || (s == ST_P_HIGH) || (s == ST_R_HIGH);
  endfunction

  // States that run the phase timer (everything except the two resting states).
  function automatic logic phase_timed(input state_t s);
    return (s != ST_IDLE) && (s != ST_PARK);
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Half-period phase counter with hold-on-stretch, plus the stretch counter and its timeout compare.
module i2c_phase_timer #(
  parameter int unsigned HALF_PERIOD     = 480,
  parameter int unsigned STRETCH_TIMEOUT = 65535,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  input  logic stretchable,
  input  logic clr,
  input  logic scl_in,
  output logic phase_end,
  output logic mid_point,
  output logic stretch_abort
);

  localparam logic [CNT_W-1:0] PHASE_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] MID_PRE      = CNT_W'(HALF_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stretch_cnt;
  logic             advance;
  logic             stretching;

  // A released phase only advances while the line is actually high.
  assign advance       = en && !clr && (!stretchable || scl_in);
  assign stretching    = en && stretchable && !scl_in;
  assign phase_end     = advance && (cnt == PHASE_LAST);
  // Fires as the counter steps onto the mid-point, so the registered strobe lands on it.
  assign mid_point     = advance && (cnt == MID_PRE);
  assign stretch_abort = stretching && (stretch_cnt == STRETCH_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      stretch_cnt <= '0;
    end else if (restart) begin
      cnt         <= '0;
      stretch_cnt <= '0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (advance) begin
        cnt <= phase_end ? '0 : cnt + CNT_W'(1);
      end
      if (stretching) begin
        stretch_cnt <= stretch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_scl_engine.sv
// Command-driven I2C SCL generator: START/XFER/STOP/RSTART sequencing, stretch handling
// and SDA drive/sample strobes for the downstream shifter.
module i2c_scl_engine
  import i2c_pkg::*;
#(
  parameter int unsigned HALF_PERIOD     = 480,
  parameter int unsigned BITS_PER_XFER   = 9,
  parameter int unsigned STRETCH_TIMEOUT = 65535,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  input  logic [1:0]                           cmd,
  output logic                                 cmd_ready,
  input  logic                                 sda_in,
  input  logic                                 scl_in,
  output logic                                 scl_oe,
  output logic                                 drive_strobe,
  output logic                                 sample_strobe,
  output logic [$clog2(BITS_PER_XFER+1)-1:0]   bit_index,
  output logic                                 done,
  output logic                                 busy,
  output logic                                 err,
  output logic                                 timeout
);

  localparam int unsigned       BIT_W    = $clog2(BITS_PER_XFER + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(BITS_PER_XFER - 1);

  state_t           state_q;
  state_t           state_d;
  cmd_t             cmd_code;
  logic             accept;
  logic [BIT_W-1:0] bit_d;
  logic             done_d;
  logic             err_d;
  logic             timeout_d;
  logic             drive_d;
  logic             sample_d;
  logic             phase_end;
  logic             mid_point;
  logic             stretch_abort;
  logic             restart;
  logic             timer_en;
  logic             timer_stretchable;
  logic             timer_clr;

  assign cmd_code = cmd_t'(cmd);
  assign accept   = cmd_valid && cmd_ready;

  // START waits for SDA to be low for a full half-period; any high SDA restarts the wait.
  assign timer_en          = phase_timed(state_q);
  assign timer_stretchable = scl_released(state_q);
  assign timer_clr         = (state_q == ST_S_WAIT) && sda_in;
  assign restart           = (state_d != state_q);

  i2c_phase_timer #(
    .HALF_PERIOD     (HALF_PERIOD),
    .STRETCH_TIMEOUT (STRETCH_TIMEOUT),
    .CNT_W           (CNT_W)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .restart       (restart),
    .en            (timer_en),
    .stretchable   (timer_stretchable),
    .clr           (timer_clr),
    .scl_in        (scl_in),
    .phase_end     (phase_end),
    .mid_point     (mid_point),
    .stretch_abort (stretch_abort)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_index;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    drive_d   = 1'b0;
    sample_d  = 1'b0;

    if (stretch_abort) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b1;
      bit_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_code == CMD_START) begin
              state_d = ST_S_WAIT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_PARK: begin
          if (accept) begin
            case (cmd_code)
              CMD_XFER: begin
                state_d = ST_X_LOW;
                drive_d = 1'b1;
              end
              CMD_STOP: begin
                state_d = ST_P_LOW;
                drive_d = 1'b1;
              end
              CMD_RSTART: begin
                state_d = ST_R_LOW;
                drive_d = 1'b1;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        ST_S_WAIT: if (phase_end) state_d = ST_S_HOLD;
        ST_S_HOLD: begin
          if (phase_end) begin
            state_d = ST_PARK;
            done_d  = 1'b1;
          end
        end
        ST_X_LOW:  if (phase_end) state_d = ST_X_HIGH;
        ST_X_HIGH: begin
          sample_d = mid_point;
          if (phase_end) begin
            if (bit_index == LAST_BIT) begin
              bit_d   = '0;
              state_d = ST_PARK;
              done_d  = 1'b1;
            end else begin
              bit_d   = bit_index + BIT_W'(1);
              state_d = ST_X_LOW;
              drive_d = 1'b1;
            end
          end
        end
        ST_P_LOW:  if (phase_end) state_d = ST_P_HIGH;
        ST_P_HIGH: begin
          if (phase_end) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_R_LOW:  if (phase_end) state_d = ST_R_HIGH;
        ST_R_HIGH: if (phase_end) state_d = ST_S_WAIT;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Level outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_oe        <= 1'b0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      bit_index     <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      timeout       <= 1'b0;
      drive_strobe  <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      scl_oe        <= scl_held_low(state_d);
      cmd_ready     <= !phase_timed(state_d);
      busy          <= phase_timed(state_d);
      bit_index     <= bit_d;
      done          <= done_d;
      err           <= err_d;
      timeout       <= timeout_d;
      drive_strobe  <= drive_d;
      sample_strobe <= sample_d;
    end
  end

endmodule

// File: tb/tb_i2c_scl_engine.sv
// Directed bench for i2c_scl_engine with a short half-period and stretch timeout.
module tb_i2c_scl_engine;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       sda_in;
  logic       scl_in;
  logic       scl_oe;
  logic       drive_strobe;
  logic       sample_strobe;
  logic [3:0] bit_index;
  logic       done;
  logic       busy;
  logic       err;
  logic       timeout;
  logic       hold;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int drv_cnt, smp_cnt, done_cnt, err_cnt, to_cnt;
  int hi_cnt, bad_smp, bad_bit, exp_bit;

  i2c_scl_engine #(
    .HALF_PERIOD     (4),
    .BITS_PER_XFER   (9),
    .STRETCH_TIMEOUT (20),
    .CNT_W           (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd),
    .cmd_ready     (cmd_ready),
    .sda_in        (sda_in),
    .scl_in        (scl_in),
    .scl_oe        (scl_oe),
    .drive_strobe  (drive_strobe),
    .sample_strobe (sample_strobe),
    .bit_index     (bit_index),
    .done          (done),
    .busy          (busy),
    .err           (err),
    .timeout       (timeout)
  );

  // Open-drain wire: low if the engine or the stretching slave pulls it.
  assign scl_in = ~scl_oe & ~hold;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    hi_cnt = scl_oe ? 0 : hi_cnt + 1;
    if (drive_strobe) begin
      drv_cnt = drv_cnt + 1;
      if (32'(bit_index) != exp_bit) bad_bit = bad_bit + 1;
      exp_bit = exp_bit + 1;
    end
    if (sample_strobe) begin
      smp_cnt = smp_cnt + 1;
      if (hi_cnt != 3) bad_smp = bad_smp + 1;
    end
    if (done)    done_cnt = done_cnt + 1;
    if (err)     err_cnt  = err_cnt + 1;
    if (timeout) to_cnt   = to_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon;
    drv_cnt = 0; smp_cnt = 0; done_cnt = 0; err_cnt = 0; to_cnt = 0;
    bad_smp = 0; bad_bit = 0; exp_bit = 0;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 300) begin
      tick;
      n++;
    end
  endtask

  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (scl_oe == lvl && n < 64) begin
      n++;
      tick;
    end
  endtask

  task automatic wait_bit_low(input int b);
    int n = 0;
    while (!(32'(bit_index) == b && scl_oe) && n < 300) begin
      tick;
      n++;
    end
  endtask

  task automatic wait_scl_released;
    int n = 0;
    while (scl_oe && n < 64) begin
      tick;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t0, hl;
    hi_cnt = 0;
    clr_mon();
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; sda_in = 1'b1; hold = 1'b0;
    repeat (3) tick;
    check("rst_scl_oe", scl_oe, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_bit_index", bit_index, 0);
    check("rst_pulses", {done, err, timeout, drive_strobe, sample_strobe}, 0);
    rst = 1'b0;
    tick;

    // START with SDA falling two cycles after accept
    clr_mon();
    send_cmd(2'b00);
    check("start_wait_busy", busy, 1);
    check("start_wait_scl", scl_oe, 0);
    tick;
    sda_in = 1'b0;
    count_level(1'b0, n);
    check("start_sda_low_len", n, 4);
    wait_done(n);
    check("start_hold_len", n, 4);
    check("start_done_cnt", done_cnt, 1);
    check("park_cmd_ready", cmd_ready, 1);
    check("park_scl_oe", scl_oe, 1);
    check("park_busy", busy, 0);
    sda_in = 1'b1;

    // Plain 9-bit transfer
    clr_mon();
    send_cmd(2'b01);
    wait_done(n);
    check("xfer_latency", n, 72);
    check("xfer_drive_cnt", drv_cnt, 9);
    check("xfer_sample_cnt", smp_cnt, 9);
    check("xfer_sample_pos", bad_smp, 0);
    check("xfer_bit_seq", bad_bit, 0);
    check("xfer_end_scl_oe", scl_oe, 1);
    check("xfer_end_bit_index", bit_index, 0);
    check("xfer_done_cnt", done_cnt, 1);

    // Transfer with a 6-cycle stretch in bit 3's high phase
    clr_mon();
    send_cmd(2'b01);
    t0 = cyc;
    wait_bit_low(3);
    hold = 1'b1;
    wait_scl_released();
    hl = 0;
    while (!scl_oe && hl < 64) begin
      hl++;
      if (hl == 7) hold = 1'b0;
      tick;
    end
    hold = 1'b0;
    check("stretch_high_len", hl, 10);
    wait_done(n);
    check("stretch_latency", cyc - t0, 78);
    check("stretch_no_timeout", to_cnt, 0);
    check("stretch_done_cnt", done_cnt, 1);
    check("stretch_sample_cnt", smp_cnt, 9);

    // START while parked is illegal
    clr_mon();
    send_cmd(2'b00);
    check("ill_park_err", err_cnt, 1);
    check("ill_park_scl_oe", scl_oe, 1);
    check("ill_park_busy", busy, 0);
    repeat (3) tick;
    check("ill_park_err_once", err_cnt, 1);
    check("ill_park_no_done", done_cnt, 0);

    // Repeated START: low 4, then released until SDA goes low
    clr_mon();
    send_cmd(2'b11);
    count_level(1'b1, n);
    check("rstart_low_len", n, 4);
    check("rstart_drive_cnt", drv_cnt, 1);
    repeat (12) tick;
    check("rstart_wait_scl", scl_oe, 0);
    check("rstart_wait_busy", busy, 1);
    check("rstart_wait_no_done", done_cnt, 0);
    sda_in = 1'b0;
    wait_done(n);
    check("rstart_finish_len", n, 8);
    check("rstart_park_scl_oe", scl_oe, 1);

    // STOP back to idle
    clr_mon();
    send_cmd(2'b10);
    count_level(1'b1, n);
    check("stop_low_len", n, 4);
    wait_done(n);
    check("stop_high_len", n, 4);
    check("stop_done_cnt", done_cnt, 1);
    check("stop_idle_busy", busy, 0);
    check("stop_idle_scl_oe", scl_oe, 0);
    check("stop_idle_ready", cmd_ready, 1);
    sda_in = 1'b1;

    // XFER while idle is illegal
    clr_mon();
    send_cmd(2'b01);
    check("ill_idle_err", err_cnt, 1);
    check("ill_idle_busy", busy, 0);
    check("ill_idle_scl_oe", scl_oe, 0);
    check("ill_idle_no_done", done_cnt, 0);

    // Stretch timeout during bit 1
    sda_in = 1'b0;
    send_cmd(2'b00);
    wait_done(n);
    check("start2_latency", n, 8);
    sda_in = 1'b1;
    clr_mon();
    send_cmd(2'b01);
    wait_bit_low(1);
    hold = 1'b1;
    wait_scl_released();
    n = 0;
    while (to_cnt == 0 && n < 64) begin
      tick;
      n++;
    end
    check("to_delay", n, 20);
    check("to_cnt", to_cnt, 1);
    check("to_scl_oe", scl_oe, 0);
    check("to_idle_busy", busy, 0);
    check("to_idle_ready", cmd_ready, 1);
    check("to_bit_index", bit_index, 0);
    check("to_no_done", done_cnt, 0);
    repeat (4) tick;
    hold = 1'b0;

    // Reset in the middle of a transfer
    sda_in = 1'b0;
    send_cmd(2'b00);
    wait_done(n);
    sda_in = 1'b1;
    clr_mon();
    send_cmd(2'b01);
    repeat (20) tick;
    check("mid_xfer_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_scl_oe", scl_oe, 0);
    check("async_rst_busy", busy, 0);
    tick;
    rst = 1'b0;
    tick;
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_bit_index", bit_index, 0);
    check("post_rst_no_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
